// File: rtl/vga_pkg.sv
// Shared constants for the VGA video generator.
//   - Pattern mode codes (MODE_SOLID .. MODE_BOX).
//   - Colour-bar on/off masks, {r,g,b}, one bit per channel.
//   - Default 640x480@60 timing constants.
//   - bar_mask(): bar index (0 = leftmost) to colour mask.
package vga_pkg;

    localparam logic [2:0] MODE_SOLID    = 3'd0;
    localparam logic [2:0] MODE_BARS     = 3'd1;
    localparam logic [2:0] MODE_CHECKER  = 3'd2;
    localparam logic [2:0] MODE_GRADIENT = 3'd3;
    localparam logic [2:0] MODE_BOX      = 3'd4;

    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_COLOR_W  = 3;
    localparam int DEF_CNT_W    = 10;

    localparam int BOX_SIZE = 32;

    function automatic logic [2:0] bar_mask(input logic [2:0] idx);
        logic [2:0] m;
        case (idx)
            3'd0:    m = BAR_WHITE;
            3'd1:    m = BAR_YELLOW;
            3'd2:    m = BAR_CYAN;
            3'd3:    m = BAR_GREEN;
            3'd4:    m = BAR_MAGENTA;
            3'd5:    m = BAR_RED;
            3'd6:    m = BAR_BLUE;
            default: m = BAR_BLACK;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Raw VGA raster counters and the flags decoded directly from them.
// Ports:
//   clk_pix, reset       pixel clock, synchronous active-high reset
//   hc, vc               raw horizontal / vertical position
//   h_last               hc is on the last clock of the line
//   hsync_act, vsync_act sync region flags (active = 1, polarity applied later)
//   de_raw               hc/vc inside the visible area
//   frame_start_raw      raster is at (0,0)
module vga_sync_counter #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CNT_W    = 10
) (
    input  logic             clk_pix,
    input  logic             reset,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             h_last,
    output logic             hsync_act,
    output logic             vsync_act,
    output logic             de_raw,
    output logic             frame_start_raw
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] H_MAX   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hc_r;
    logic [CNT_W-1:0] vc_r;

    // Raster counters: hc wraps each line, vc advances on hc wrap and wraps each frame
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            hc_r <= '0;
            vc_r <= '0;
        end else if (hc_r == H_MAX) begin
            hc_r <= '0;
            if (vc_r == V_MAX) begin
                vc_r <= '0;
            end else begin
                vc_r <= vc_r + ONE;
            end
        end else begin
            hc_r <= hc_r + ONE;
        end
    end

    assign hc              = hc_r;
    assign vc              = vc_r;
    assign h_last          = (hc_r == H_MAX);
    assign hsync_act       = (hc_r >= HS_BEG) && (hc_r < HS_END);
    assign vsync_act       = (vc_r >= VS_BEG) && (vc_r < VS_END);
    assign de_raw          = (hc_r < H_VIS) && (vc_r < V_VIS);
    assign frame_start_raw = (hc_r == '0) && (vc_r == '0);

endmodule

// File: rtl/vga_video_gen.sv
// Programmable VGA timing plus test-pattern generator, pixel clock domain.
// Ports:
//   clk_pix, reset        pixel clock, synchronous active-high reset
//   mode[2:0]             pattern select, taken once per frame at pixel (0,0)
//   hsync, vsync          sync outputs, active level H_POL / V_POL
//   de                    data enable (visible area)
//   rgb_r/rgb_g/rgb_b     pixel colour, zero outside the visible area
//   hcount, vcount        coordinates of the pixel currently on rgb
//   frame_start           one-clock pulse together with pixel (0,0)
// All outputs lag the raw counters by two registered stages.
// Optional macro VGA_VIDEO_GEN_ANIM_EN: mode 4 draws a 32x32 white box
// sliding right by one pixel per frame; without it mode 4 is black.
module vga_video_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int COLOR_W  = DEF_COLOR_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic               clk_pix,
    input  logic               reset,
    input  logic [2:0]         mode,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COLOR_W-1:0] rgb_r,
    output logic [COLOR_W-1:0] rgb_g,
    output logic [COLOR_W-1:0] rgb_b,
    output logic [CNT_W-1:0]   hcount,
    output logic [CNT_W-1:0]   vcount,
    output logic               frame_start
);

    localparam logic [CNT_W-1:0]   ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);
    localparam logic [COLOR_W-1:0] FULL     = {COLOR_W{1'b1}};

    logic [CNT_W-1:0] hc_s;
    logic [CNT_W-1:0] vc_s;
    logic             h_last_s;
    logic             hsync_act_s;
    logic             vsync_act_s;
    logic             de_raw_s;
    logic             frame_start_raw_s;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .CNT_W    (CNT_W)
    ) u_sync (
        .clk_pix         (clk_pix),
        .reset           (reset),
        .hc              (hc_s),
        .vc              (vc_s),
        .h_last          (h_last_s),
        .hsync_act       (hsync_act_s),
        .vsync_act       (vsync_act_s),
        .de_raw          (de_raw_s),
        .frame_start_raw (frame_start_raw_s)
    );

    logic [2:0]         mode_q_r;
    logic [2:0]         mode_eff_s;
    logic [CNT_W-1:0]   bar_px_r;
    logic [2:0]         bar_idx_r;
    logic [2:0]         bar_rgb_s;
    logic [COLOR_W-1:0] grey_s;
    logic [COLOR_W-1:0] pix_r_s;
    logic [COLOR_W-1:0] pix_g_s;
    logic [COLOR_W-1:0] pix_b_s;

    logic               s1_hsync_r;
    logic               s1_vsync_r;
    logic               s1_de_r;
    logic               s1_fs_r;
    logic [CNT_W-1:0]   s1_hc_r;
    logic [CNT_W-1:0]   s1_vc_r;
    logic [COLOR_W-1:0] s1_r_r;
    logic [COLOR_W-1:0] s1_g_r;
    logic [COLOR_W-1:0] s1_b_r;

    // Mode latch: only updated at raster (0,0) so a frame never mixes patterns
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            mode_q_r <= 3'd0;
        end else if (frame_start_raw_s) begin
            mode_q_r <= mode;
        end else begin
            mode_q_r <= mode_q_r;
        end
    end

    // Pixel (0,0) itself must already use the newly latched mode
    always_comb begin
        mode_eff_s = mode_q_r;
        if (frame_start_raw_s) begin
            mode_eff_s = mode;
        end else begin
            mode_eff_s = mode_q_r;
        end
    end

    // Bar sub-counter tracking hc: cleared on line wrap so bar 0 starts at hc==0
    always_ff @(posedge clk_pix) begin
        if (reset || h_last_s) begin
            bar_px_r  <= '0;
            bar_idx_r <= 3'd0;
        end else if (bar_px_r == BAR_LAST) begin
            bar_px_r  <= '0;
            bar_idx_r <= bar_idx_r + 3'd1;
        end else begin
            bar_px_r  <= bar_px_r + ONE;
            bar_idx_r <= bar_idx_r;
        end
    end

    assign bar_rgb_s = bar_mask(bar_idx_r);
    assign grey_s    = hc_s[CNT_W-1 -: COLOR_W];

`ifdef VGA_VIDEO_GEN_ANIM_EN
    localparam logic [CNT_W-1:0] BOX_W      = CNT_W'(BOX_SIZE);
    localparam logic [CNT_W-1:0] BOX_X_LAST = CNT_W'(H_ACTIVE - BOX_SIZE);
    localparam logic [CNT_W-1:0] BOX_Y0     = CNT_W'(V_ACTIVE / 2 - BOX_SIZE / 2);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [CNT_W-1:0] box_x_r;
    logic             in_box_s;

    // Box position: stepped on the last raster clock so the new x holds from (0,0)
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            box_x_r <= '0;
        end else if (h_last_s && (vc_s == V_LAST)) begin
            if (box_x_r == BOX_X_LAST) begin
                box_x_r <= '0;
            end else begin
                box_x_r <= box_x_r + ONE;
            end
        end else begin
            box_x_r <= box_x_r;
        end
    end

    assign in_box_s = (hc_s >= box_x_r) && (hc_s < box_x_r + BOX_W) &&
                      (vc_s >= BOX_Y0) && (vc_s < BOX_Y0 + BOX_W);
`endif

    // Pattern generation from the raw coordinates; black outside the visible area
    always_comb begin
        pix_r_s = '0;
        pix_g_s = '0;
        pix_b_s = '0;
        if (de_raw_s) begin
            case (mode_eff_s)
                MODE_SOLID: begin
                    pix_r_s = FULL;
                    pix_g_s = FULL;
                    pix_b_s = FULL;
                end
                MODE_BARS: begin
                    pix_r_s = {COLOR_W{bar_rgb_s[2]}};
                    pix_g_s = {COLOR_W{bar_rgb_s[1]}};
                    pix_b_s = {COLOR_W{bar_rgb_s[0]}};
                end
                MODE_CHECKER: begin
                    pix_r_s = {COLOR_W{hc_s[5] ^ vc_s[5]}};
                    pix_g_s = {COLOR_W{hc_s[5] ^ vc_s[5]}};
                    pix_b_s = {COLOR_W{hc_s[5] ^ vc_s[5]}};
                end
                MODE_GRADIENT: begin
                    pix_r_s = grey_s;
                    pix_g_s = grey_s;
                    pix_b_s = grey_s;
                end
                MODE_BOX: begin
`ifdef VGA_VIDEO_GEN_ANIM_EN
                    pix_r_s = {COLOR_W{in_box_s}};
                    pix_g_s = {COLOR_W{in_box_s}};
                    pix_b_s = {COLOR_W{in_box_s}};
`else
                    pix_r_s = '0;
                    pix_g_s = '0;
                    pix_b_s = '0;
`endif
                end
                default: begin
                    pix_r_s = '0;
                    pix_g_s = '0;
                    pix_b_s = '0;
                end
            endcase
        end else begin
            pix_r_s = '0;
            pix_g_s = '0;
            pix_b_s = '0;
        end
    end

    // Stage 1: capture raw flags, coordinates and pattern colour
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            s1_hsync_r <= 1'b0;
            s1_vsync_r <= 1'b0;
            s1_de_r    <= 1'b0;
            s1_fs_r    <= 1'b0;
            s1_hc_r    <= '0;
            s1_vc_r    <= '0;
            s1_r_r     <= '0;
            s1_g_r     <= '0;
            s1_b_r     <= '0;
        end else begin
            s1_hsync_r <= hsync_act_s;
            s1_vsync_r <= vsync_act_s;
            s1_de_r    <= de_raw_s;
            s1_fs_r    <= frame_start_raw_s;
            s1_hc_r    <= hc_s;
            s1_vc_r    <= vc_s;
            s1_r_r     <= pix_r_s;
            s1_g_r     <= pix_g_s;
            s1_b_r     <= pix_b_s;
        end
    end

    // Stage 2: output registers, sync polarity applied here
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            de          <= 1'b0;
            frame_start <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            rgb_r       <= '0;
            rgb_g       <= '0;
            rgb_b       <= '0;
        end else begin
            hsync       <= s1_hsync_r ? H_POL : ~H_POL;
            vsync       <= s1_vsync_r ? V_POL : ~V_POL;
            de          <= s1_de_r;
            frame_start <= s1_fs_r;
            hcount      <= s1_hc_r;
            vcount      <= s1_vc_r;
            rgb_r       <= s1_r_r;
            rgb_g       <= s1_g_r;
            rgb_b       <= s1_b_r;
        end
    end

endmodule

// File: tb/tb_vga_video_gen.sv
// Directed bench for vga_video_gen. One instance uses the default 640x480
// timing for line-level checks; a second uses a small 40x36 raster
// (48x40 total, 1920 clocks per frame) for frame-level behaviour.
module tb_vga_video_gen;

    localparam int FRAME_S = 1920;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] mode_d;
    logic [2:0] mode_s;

    always #5 clk = ~clk;

    logic       hsync_d, vsync_d, de_d, fs_d;
    logic [2:0] r_d, g_d, b_d;
    logic [9:0] hcount_d, vcount_d;

    logic       hsync_s, vsync_s, de_s, fs_s;
    logic [2:0] r_s, g_s, b_s;
    logic [5:0] hcount_s, vcount_s;

    logic [8:0] rgb_d;
    logic [8:0] rgb_s;
    assign rgb_d = {r_d, g_d, b_d};
    assign rgb_s = {r_s, g_s, b_s};

    vga_video_gen u_dut_d (
        .clk_pix (clk), .reset (reset), .mode (mode_d),
        .hsync (hsync_d), .vsync (vsync_d), .de (de_d),
        .rgb_r (r_d), .rgb_g (g_d), .rgb_b (b_d),
        .hcount (hcount_d), .vcount (vcount_d), .frame_start (fs_d)
    );

    vga_video_gen #(
        .H_ACTIVE (40), .H_FP (2), .H_SYNC (4), .H_BP (2),
        .V_ACTIVE (36), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .COLOR_W  (3),  .CNT_W (6)
    ) u_dut_s (
        .clk_pix (clk), .reset (reset), .mode (mode_s),
        .hsync (hsync_s), .vsync (vsync_s), .de (de_s),
        .rgb_r (r_s), .rgb_g (g_s), .rgb_b (b_s),
        .hcount (hcount_s), .vcount (vcount_s), .frame_start (fs_s)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int pix          = 0;
    int frame        = 0;
    int de_cnt, hs_first, hs_cnt, n;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; pix/frame track the small instance's output position
    task automatic tick();
        @(posedge clk);
        #1;
        if (pix == FRAME_S - 1) begin
            pix = 0;
            frame++;
        end else begin
            pix++;
        end
    endtask

    task automatic goto(input int f, input int p);
        for (int k = 0; k < 40000 && !(frame == f && pix == p); k++) tick();
        if (!(frame == f && pix == p))
            check_val("goto_timeout", frame * FRAME_S + pix, f * FRAME_S + p);
    endtask

    task automatic check_px(input string tag, input int f, input int p, input logic [8:0] exp);
        goto(f, p);
        check_val(tag, {23'd0, rgb_s}, {23'd0, exp});
    endtask

    initial begin
        reset  = 1'b1;
        mode_d = 3'd1;
        mode_s = 3'd0;
        repeat (5) tick();

        // Reset state
        check_val("rst_hsync_d", hsync_d, 1);
        check_val("rst_vsync_d", vsync_d, 1);
        check_val("rst_de_d", de_d, 0);
        check_val("rst_rgb_d", rgb_d, 0);
        check_val("rst_hcount_d", hcount_d, 0);
        check_val("rst_fs_d", fs_d, 0);
        check_val("rst_hsync_s", hsync_s, 1);
        check_val("rst_vsync_s", vsync_s, 1);

        // First frame_start two clocks after release
        reset = 1'b0;
        tick();
        check_val("fs_lat1", fs_d, 0);
        tick();
        check_val("fs_lat2_d", fs_d, 1);
        check_val("fs_lat2_s", fs_s, 1);

        // Default timing, mode 1, one full line
        de_cnt = 0; hs_first = -1; hs_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (de_d) de_cnt++;
            if (!hsync_d) begin
                if (hs_first < 0) hs_first = i;
                hs_cnt++;
            end
            case (i)
                0:   check_val("bar_px0", rgb_d, 9'o777);
                79:  check_val("bar_px79", rgb_d, 9'o777);
                80:  check_val("bar_px80", rgb_d, 9'o770);
                123: check_val("hcount_123", hcount_d, 123);
                560: check_val("bar_px560", rgb_d, 9'o000);
                639: check_val("bar_px639_de", de_d, 1);
                640: begin
                    check_val("rgb_px640", rgb_d, 9'o000);
                    check_val("de_px640", de_d, 0);
                end
                default: ;
            endcase
            tick();
        end
        check_val("de_width", de_cnt, 640);
        check_val("hsync_start", hs_first, 656);
        check_val("hsync_width", hs_cnt, 96);

        // Small raster from a fresh reset
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        tick();
        pix = 0; frame = 1;
        check_val("s_fs_first", fs_s, 1);
        check_val("s_px0_solid", rgb_s, 9'o777);

        n = 0;
        do begin
            tick();
            n++;
        end while (!fs_s && n < 4000);
        check_val("fs_period", n, FRAME_S);

        // Mid-frame mode change is deferred to the next frame
        mode_s = 3'd1;
        check_px("mid_frame_ignored", 2, 10, 9'o777);

        check_px("bars_0", 3, 0, 9'o777);
        check_px("bars_5", 3, 5, 9'o770);
        check_px("bars_10", 3, 10, 9'o077);
        check_px("bars_30", 3, 30, 9'o007);
        check_px("bars_35", 3, 35, 9'o000);
        check_px("bars_40_blank", 3, 40, 9'o000);
        check_val("de_40", de_s, 0);
        goto(3, 41); check_val("hsync_41", hsync_s, 1);
        goto(3, 42); check_val("hsync_42", hsync_s, 0);
        goto(3, 45); check_val("hsync_45", hsync_s, 0);
        goto(3, 46); check_val("hsync_46", hsync_s, 1);
        goto(3, 151);
        check_val("hcount_151", hcount_s, 7);
        check_val("vcount_151", vcount_s, 3);
        goto(3, 480);
        mode_s = 3'd2;
        check_px("bars_continue", 3, 970, 9'o077);
        goto(3, 1728);
        check_val("vsync_l36", vsync_s, 1);
        check_val("de_l36", de_s, 0);
        goto(3, 1776); check_val("vsync_l37", vsync_s, 0);
        goto(3, 1871); check_val("vsync_l38_end", vsync_s, 0);
        goto(3, 1872); check_val("vsync_l39", vsync_s, 1);

        // Checkerboard
        check_px("chk_0_0", 4, 0, 9'o000);
        check_px("chk_32_0", 4, 32, 9'o777);
        check_px("chk_0_32", 4, 1536, 9'o777);
        check_px("chk_32_32", 4, 1568, 9'o000);
        mode_s = 3'd3;

        // Grey gradient, channel = hc[5:3]
        check_px("grad_8", 5, 8, 9'o111);
        check_px("grad_39", 5, 39, 9'o444);
        check_px("grad_l5_20", 5, 260, 9'o222);
        mode_s = 3'd4;

`ifdef VGA_VIDEO_GEN_ANIM_EN
        // box_x = frame-1 (mod 9), rows 2..33
        check_px("box_f6_l1", 6, 53, 9'o000);
        check_px("box_f6_left_out", 6, 100, 9'o000);
        check_px("box_f6_left", 6, 101, 9'o777);
        check_px("box_f6_right", 6, 1620, 9'o777);
        check_px("box_f6_right_out", 6, 1621, 9'o000);
        check_px("box_f6_below", 6, 1637, 9'o000);
        check_px("box_f7_left", 7, 102, 9'o777);
        check_px("box_f8_left", 8, 103, 9'o777);
        check_px("box_f9_out", 9, 103, 9'o000);
        check_px("box_f9_left", 9, 104, 9'o777);
        check_px("box_f9_right", 9, 135, 9'o777);
        check_px("box_wrap_left", 10, 96, 9'o777);
        check_px("box_wrap_out", 10, 128, 9'o000);
`else
        check_px("box_off_a", 6, 101, 9'o000);
        check_px("box_off_b", 6, 1620, 9'o000);
        mode_s = 3'd7;
        check_px("mode7_0", 7, 0, 9'o000);
        check_val("mode7_de", de_s, 1);
        check_px("mode7_500", 7, 500, 9'o000);
`endif

        // Reset in the middle of line 20
        goto(frame, 963);
        mode_s = 3'd0;
        reset  = 1'b1;
        tick();
        check_val("mrst_hsync", hsync_s, 1);
        check_val("mrst_vsync", vsync_s, 1);
        check_val("mrst_de", de_s, 0);
        check_val("mrst_rgb", rgb_s, 0);
        check_val("mrst_hcount", hcount_s, 0);
        check_val("mrst_vcount", vcount_s, 0);
        check_val("mrst_fs", fs_s, 0);
        reset = 1'b0;
        tick();
        check_val("mrst_fs_lat1", fs_s, 0);
        check_val("mrst_hsync_lat1", hsync_s, 1);
        tick();
        pix = 0; frame = 1;
        check_val("mrst_fs_lat2", fs_s, 1);
        check_val("mrst_h0", hcount_s, 0);
        check_val("mrst_v0", vcount_s, 0);
        check_val("mrst_rgb0", rgb_s, 9'o777);
        goto(1, 42);
        check_val("mrst_hsync_restart", hsync_s, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
